// File: rtl/mem_access_pkg.sv
// Shared types and constants for the asynchronous word-memory front-end.
package mem_access_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 16;
  localparam int STRB_CNT_W = 4;

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, RESP} state_e;
endpackage

// File: rtl/mem_access_ctrl_if.sv
// Request/response handshake bundle between the load/store unit and mem_access_ctrl.
interface mem_access_ctrl_if import mem_access_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_write;
  logic [DATA_W-1:0] rsp_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_write, rsp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_write, rsp_rdata
  );
endinterface

// File: rtl/mem_bus_io.sv
// Tri-state driver for the shared memory data bus plus the read-capture register.
module mem_bus_io import mem_access_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              drive_en,
  input  logic [DATA_W-1:0] wdata,
  input  logic              capture_en,
  output logic [DATA_W-1:0] rdata,
  inout  wire  [DATA_W-1:0] mem_bus
);
  assign mem_bus = drive_en ? wdata : {DATA_W{1'bz}};

  always_ff @(posedge clk) begin
    if (!rst_n)          rdata <= '0;
    else if (capture_en) rdata <= mem_bus;
  end
endmodule

// File: rtl/mem_access_ctrl.sv
// Sequences single-word accesses to the async enable-strobed memory (setup/strobe/hold).
// Optional stats counters: define MEM_ACCESS_CTRL_STATS_EN.
module mem_access_ctrl import mem_access_pkg::*; #(
  parameter int DATA_W        = DEF_DATA_W,
  parameter int ADDR_W        = DEF_ADDR_W,
  parameter int STROBE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_access_ctrl_if.slave  ifc,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_enable,
  inout  wire  [DATA_W-1:0] mem_bus
`ifdef MEM_ACCESS_CTRL_STATS_EN
  ,
  input  logic              stat_clr,
  output logic [31:0]       stat_rd_cnt,
  output logic [31:0]       stat_wr_cnt
`endif
);
  if (STROBE_CYCLES < 1 || STROBE_CYCLES > 15) begin : g_bad_strobe
    $error("STROBE_CYCLES must be in 1..15");
  end

  state_e                state, state_nx;
  logic [STRB_CNT_W-1:0] strb_cnt;
  logic [ADDR_W-1:0]     addr_q;
  logic [DATA_W-1:0]     wdata_q, rdata_cap;
  logic                  wr_q, drive_q, rsp_valid_q;
  logic                  accept, rsp_hs, active;

  assign ifc.req_ready = rst_n && (state == IDLE);
  assign accept        = ifc.req_valid && ifc.req_ready;
  assign rsp_hs        = rsp_valid_q && ifc.rsp_ready;
  assign active        = (state == SETUP) || (state == STROBE) || (state == HOLD);

  assign ifc.rsp_valid = rsp_valid_q;
  assign ifc.rsp_write = wr_q;
  assign ifc.rsp_rdata = wr_q ? '0 : rdata_cap;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = SETUP;
      SETUP:   state_nx = STROBE;
      STROBE:  if (strb_cnt == '0) state_nx = HOLD;
      HOLD:    state_nx = RESP;
      RESP:    if (rsp_hs) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Memory pins are registered from the current state, so each pin phase trails
  // its FSM state by one cycle; the response follows once the pin HOLD has ended.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      strb_cnt    <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wr_q        <= 1'b0;
      mem_addr    <= '0;
      mem_read    <= 1'b1;
      mem_enable  <= 1'b0;
      drive_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      if (accept) begin
        addr_q  <= ifc.req_addr;
        wdata_q <= ifc.req_wdata;
        wr_q    <= ifc.req_write;
      end
      if (state == SETUP)       strb_cnt <= STRB_CNT_W'(STROBE_CYCLES - 1);
      else if (state == STROBE) strb_cnt <= strb_cnt - STRB_CNT_W'(1);
      if (state == SETUP) mem_addr <= addr_q;
      mem_read    <= !(active && wr_q);
      drive_q     <= active && wr_q;
      mem_enable  <= (state == STROBE);
      rsp_valid_q <= (state == RESP) && !rsp_hs;
    end
  end

  // Capture lands on the edge that ends the pin strobe (state HOLD trails it by one).
  mem_bus_io #(.DATA_W(DATA_W)) u_bus_io (
    .clk        (clk),
    .rst_n      (rst_n),
    .drive_en   (drive_q),
    .wdata      (wdata_q),
    .capture_en ((state == HOLD) && !wr_q),
    .rdata      (rdata_cap),
    .mem_bus    (mem_bus)
  );

`ifdef MEM_ACCESS_CTRL_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n || stat_clr) begin
      stat_rd_cnt <= '0;
      stat_wr_cnt <= '0;
    end else if (rsp_hs) begin
      if (wr_q) stat_wr_cnt <= stat_wr_cnt + 32'd1;
      else      stat_rd_cnt <= stat_rd_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: STROBE_CYCLES=1 and =3 instances, async memory models, scoreboard.
module tb_mem_access_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  mem_access_ctrl_if #(.DATA_W(32), .ADDR_W(16)) ifc0 ();
  mem_access_ctrl_if #(.DATA_W(32), .ADDR_W(16)) ifc1 ();
  wire  [31:0] bus0, bus1;
  logic [15:0] addr0, addr1;
  logic        rd0, rd1, en0, en1;

`ifdef MEM_ACCESS_CTRL_STATS_EN
  logic        clr0 = 1'b0, clr1 = 1'b0;
  logic [31:0] rdc0, wrc0, rdc1, wrc1;
`endif

  mem_access_ctrl #(.DATA_W(32), .ADDR_W(16), .STROBE_CYCLES(1)) u0 (
    .clk(clk), .rst_n(rst_n), .ifc(ifc0),
    .mem_addr(addr0), .mem_read(rd0), .mem_enable(en0), .mem_bus(bus0)
`ifdef MEM_ACCESS_CTRL_STATS_EN
    , .stat_clr(clr0), .stat_rd_cnt(rdc0), .stat_wr_cnt(wrc0)
`endif
  );

  mem_access_ctrl #(.DATA_W(32), .ADDR_W(16), .STROBE_CYCLES(3)) u1 (
    .clk(clk), .rst_n(rst_n), .ifc(ifc1),
    .mem_addr(addr1), .mem_read(rd1), .mem_enable(en1), .mem_bus(bus1)
`ifdef MEM_ACCESS_CTRL_STATS_EN
    , .stat_clr(clr1), .stat_rd_cnt(rdc1), .stat_wr_cnt(wrc1)
`endif
  );

  // Asynchronous memory devices: drive the bus while enabled for read, write while enabled.
  logic [31:0] dev0 [0:65535];
  logic [31:0] dev1 [0:65535];
  logic        pl_we = 1'b0, pl_sel = 1'b0;
  logic [15:0] pl_a = '0;
  logic [31:0] pl_d = '0;

  assign bus0 = (en0 && rd0) ? dev0[addr0] : {32{1'bz}};
  assign bus1 = (en1 && rd1) ? dev1[addr1] : {32{1'bz}};

  always @(posedge clk) begin
    if (pl_we) begin
      if (pl_sel) dev1[pl_a] <= pl_d;
      else        dev0[pl_a] <= pl_d;
    end
    if (en0 && !rd0) dev0[addr0] <= bus0;
    if (en1 && !rd1) dev1[addr1] <= bus1;
  end

  // Reference model state
  logic [31:0] ref_mem [int];
  logic [31:0] cur_wdata0 = '0;
  int          rd_hs = 0, wr_hs = 0;
  logic [15:0] pool [8] = '{16'h0000, 16'h0001, 16'h0010, 16'h7FFF,
                            16'h8000, 16'hFFFE, 16'hFFFF, 16'h1234};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic sel, input logic [15:0] a, input logic [31:0] d);
    @(negedge clk);
    pl_we = 1'b1; pl_sel = sel; pl_a = a; pl_d = d;
    @(posedge clk); #1;
    pl_we = 1'b0;
  endtask

  task automatic do_req0(input logic w, input logic [15:0] a, input logic [31:0] d,
                         input int stall, input logic clr);
    int k;
    logic [31:0] exp_rd;
    exp_rd = w ? 32'h0 : ref_mem[a];
    @(negedge clk);
    ifc0.req_valid = 1'b1; ifc0.req_write = w; ifc0.req_addr = a; ifc0.req_wdata = d;
    k = 0;
    while (!ifc0.req_ready && k < 50) begin @(negedge clk); k++; end
    chk("accept_timeout", k < 50, 1);
    cur_wdata0 = d;
    @(posedge clk); #1;
    ifc0.req_valid = 1'b0;
    if (w) ref_mem[a] = d;
    k = 0;
    while (!ifc0.rsp_valid && k < 30) begin @(posedge clk); #1; k++; end
    chk("rsp_latency", k, 4);
    chk("rsp_write", ifc0.rsp_write, w);
    chk("rsp_rdata", ifc0.rsp_rdata, exp_rd);
    repeat (stall) begin
      @(posedge clk); #1;
      chk("stall_valid", ifc0.rsp_valid, 1);
      chk("stall_rdata", ifc0.rsp_rdata, exp_rd);
      chk("stall_ready", ifc0.req_ready, 0);
    end
    @(negedge clk);
    ifc0.rsp_ready = 1'b1;
`ifdef MEM_ACCESS_CTRL_STATS_EN
    clr0 = clr;
`endif
    @(posedge clk); #1;
    ifc0.rsp_ready = 1'b0;
`ifdef MEM_ACCESS_CTRL_STATS_EN
    clr0 = 1'b0;
`endif
    if (clr) begin rd_hs = 0; wr_hs = 0; end
    else if (w) wr_hs++;
    else rd_hs++;
    chk("rsp_dropped", ifc0.rsp_valid, 0);
    chk("req_ready_after_hs", ifc0.req_ready, 1);
`ifdef MEM_ACCESS_CTRL_STATS_EN
    chk("stat_rd", rdc0, rd_hs);
    chk("stat_wr", wrc0, wr_hs);
`endif
  endtask

  // Pin monitor: stable addr/read under enable, bus content, strobe widths
  logic        pen0 = 1'b0;
  logic [15:0] paddr0 = '0;
  logic        prd0 = 1'b1;
  int          wid0 = 0, wid1 = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      wid0 = 0; wid1 = 0;
    end else begin
      if (en0 && pen0) begin
        chk("addr_stable", addr0, paddr0);
        chk("read_stable", rd0, prd0);
      end
      if (!rd0) chk("bus_wdata", bus0, cur_wdata0);
      if (en0 && rd0) chk("bus_known0", $isunknown(bus0), 0);
      if (en1 && rd1) chk("bus_known1", $isunknown(bus1), 0);
      if (en0) wid0++;
      else if (wid0 != 0) begin chk("strobe_width1", wid0, 1); wid0 = 0; end
      if (en1) wid1++;
      else if (wid1 != 0) begin chk("strobe_width3", wid1, 3); wid1 = 0; end
    end
    pen0 = en0; paddr0 = addr0; prd0 = rd0;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog_timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    logic [31:0] v;
    ifc0.req_valid = 1'b0; ifc0.req_write = 1'b0; ifc0.req_addr = '0; ifc0.req_wdata = '0;
    ifc0.rsp_ready = 1'b0;
    ifc1.req_valid = 1'b0; ifc1.req_write = 1'b0; ifc1.req_addr = '0; ifc1.req_wdata = '0;
    ifc1.rsp_ready = 1'b0;
    rst_n = 1'b0;

    for (int i = 0; i < 8; i++) begin
      v = $urandom;
      ref_mem[pool[i]] = v;
      preload(1'b0, pool[i], v);
    end
    preload(1'b1, 16'hFFFF, 32'h12345678);

    // Reset state
    chk("rst_enable", en0, 0);
    chk("rst_read", rd0, 1);
    chk("rst_addr", addr0, 0);
    chk("rst_rsp_valid", ifc0.rsp_valid, 0);
    chk("rst_rsp_write", ifc0.rsp_write, 0);
    chk("rst_rsp_rdata", ifc0.rsp_rdata, 0);
    chk("rst_req_ready", ifc0.req_ready, 0);
`ifdef MEM_ACCESS_CTRL_STATS_EN
    chk("rst_stat_rd", rdc0, 0);
    chk("rst_stat_wr", wrc0, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Write then read back, and a backpressured read of the top address
    do_req0(1'b1, 16'h0010, 32'hDEADBEEF, 0, 1'b0);
    do_req0(1'b0, 16'h0010, 32'h0, 0, 1'b0);
    do_req0(1'b0, 16'hFFFF, 32'h0, 5, 1'b0);

    // STROBE_CYCLES = 3 instance: read of 0xFFFF
    @(negedge clk);
    chk("s3_req_ready", ifc1.req_ready, 1);
    ifc1.req_valid = 1'b1; ifc1.req_write = 1'b0; ifc1.req_addr = 16'hFFFF;
    @(posedge clk); #1;
    ifc1.req_valid = 1'b0;
    k = 0;
    while (!ifc1.rsp_valid && k < 30) begin @(posedge clk); #1; k++; end
    chk("s3_latency", k, 6);
    chk("s3_rdata", ifc1.rsp_rdata, 32'h12345678);
    chk("s3_rsp_write", ifc1.rsp_write, 0);
    @(negedge clk);
    ifc1.rsp_ready = 1'b1;
    @(posedge clk); #1;
    ifc1.rsp_ready = 1'b0;
    chk("s3_rsp_dropped", ifc1.rsp_valid, 0);

    // Random traffic over the preloaded pool
    for (int i = 0; i < 200; i++)
      do_req0(1'($urandom_range(0, 1)), pool[$urandom_range(0, 7)], $urandom,
              int'($urandom_range(0, 2)), 1'b0);

    // Reset during the strobe of a write to an address outside the pool
    @(negedge clk);
    ifc0.req_valid = 1'b1; ifc0.req_write = 1'b1; ifc0.req_addr = 16'h0100;
    ifc0.req_wdata = 32'hA5A5A5A5;
    cur_wdata0 = 32'hA5A5A5A5;
    @(posedge clk); #1;
    ifc0.req_valid = 1'b0;
    k = 0;
    while (!en0 && k < 20) begin @(negedge clk); k++; end
    chk("midrst_saw_strobe", en0, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_enable", en0, 0);
    chk("midrst_bus_released", rd0, 1);
    chk("midrst_rsp_valid", ifc0.rsp_valid, 0);
    chk("midrst_req_ready", ifc0.req_ready, 0);
    @(posedge clk); #1;
    chk("midrst_req_ready2", ifc0.req_ready, 0);
    chk("midrst_rsp_valid2", ifc0.rsp_valid, 0);
    rd_hs = 0; wr_hs = 0;
    @(negedge clk);
    rst_n = 1'b1;
    do_req0(1'b0, 16'h0010, 32'h0, 0, 1'b0);

`ifdef MEM_ACCESS_CTRL_STATS_EN
    @(negedge clk);
    clr0 = 1'b1;
    @(posedge clk); #1;
    clr0 = 1'b0;
    rd_hs = 0; wr_hs = 0;
    chk("clr_stat_rd", rdc0, 0);
    chk("clr_stat_wr", wrc0, 0);
    do_req0(1'b0, pool[0], 32'h0, 0, 1'b0);
    do_req0(1'b1, pool[1], 32'h11111111, 0, 1'b0);
    do_req0(1'b0, pool[2], 32'h0, 1, 1'b0);
    do_req0(1'b1, pool[3], 32'h22222222, 0, 1'b0);
    do_req0(1'b0, pool[1], 32'h0, 0, 1'b0);
    chk("stat_rd_3", rdc0, 3);
    chk("stat_wr_2", wrc0, 2);
    do_req0(1'b0, pool[3], 32'h0, 0, 1'b1);
    chk("stat_clr_wins_rd", rdc0, 0);
    chk("stat_clr_wins_wr", wrc0, 0);
`endif

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
